// File: rtl/mldsa_axis_bridge_if.sv
// Stream and core handshake bundle for mldsa_axis_bridge.
// The slave modport is the bridge's view; the master modport is the
// surrounding system (stream sources/sinks and the ML-DSA core).
interface mldsa_axis_bridge_if #(
  parameter int DATA_W = 64,
  parameter int NUM_IN = 2
);
  logic [NUM_IN*DATA_W-1:0] s_axis_tdata;
  logic [NUM_IN-1:0]        s_axis_tvalid;
  logic [NUM_IN-1:0]        s_axis_tlast;
  logic [NUM_IN-1:0]        s_axis_tready;

  logic [NUM_IN*DATA_W-1:0] core_data_in;
  logic [NUM_IN-1:0]        core_i_valid;
  logic [NUM_IN-1:0]        core_i_last;
  logic [NUM_IN-1:0]        core_i_ready;

  logic [DATA_W-1:0]        core_data_out;
  logic                     core_o_valid;
  logic                     core_o_last;
  logic                     core_o_ready;

  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic                     m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output core_data_in, core_i_valid, core_i_last,
    input  core_i_ready,
    input  core_data_out, core_o_valid, core_o_last,
    output core_o_ready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  core_data_in, core_i_valid, core_i_last,
    output core_i_ready,
    output core_data_out, core_o_valid, core_o_last,
    input  core_o_ready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/mldsa_axis_bridge.sv
// mldsa_axis_bridge: buffers NUM_IN AXI-Stream inputs into the ML-DSA core
// and the core result back out to m_axis. Every path is a first-word-fall-
// through FIFO of {tlast, tdata} with a packet tracker and done pulse.
// Optional statistics counters are built when MLDSA_AXIS_BRIDGE_STATS_EN is
// defined; otherwise the stat ports are tied to zero.
module mldsa_axis_bridge #(
  parameter int DATA_W    = 64,
  parameter int NUM_IN    = 2,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  mldsa_axis_bridge_if.slave bus,
  output logic [NUM_IN-1:0]  in_pkt_done,
  output logic               out_pkt_done,
  output logic               busy,
  output logic [31:0]        stat_in_beats,
  output logic [31:0]        stat_out_beats,
  output logic [31:0]        stat_out_pkts
);
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [IN_AW:0]  IN_FULL_CNT  = IN_DEPTH[IN_AW:0];
  localparam logic [OUT_AW:0] OUT_FULL_CNT = OUT_DEPTH[OUT_AW:0];

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} pkt_state_t;

  logic [NUM_IN-1:0] in_push, in_pop, in_empty, in_full, in_last, in_active;
  logic [DATA_W-1:0] in_data [NUM_IN];
  logic [NUM_IN-1:0] in_done_p1;

  logic              out_push, out_pop, out_empty, out_full, out_last, out_active;
  logic [DATA_W-1:0] out_data;
  logic              out_done_p1;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    logic [DATA_W:0]  mem [IN_DEPTH];
    logic [IN_AW-1:0] wptr, rptr;
    logic [IN_AW:0]   cnt;
    pkt_state_t       state, state_nxt;

    assign in_full[i]   = (cnt == IN_FULL_CNT);
    assign in_empty[i]  = (cnt == '0);
    assign in_push[i]   = bus.s_axis_tvalid[i] & ~in_full[i] & ~flush;
    assign in_pop[i]    = bus.core_i_ready[i] & ~in_empty[i] & ~flush;
    assign in_data[i]   = mem[rptr][DATA_W-1:0];
    assign in_last[i]   = mem[rptr][DATA_W];
    assign in_active[i] = (state == IN_PKT);

    // Beat storage; occupancy gates every read, so contents need no reset.
    always_ff @(posedge clk) begin
      if (in_push[i]) mem[wptr] <= {bus.s_axis_tlast[i], bus.s_axis_tdata[i*DATA_W +: DATA_W]};
    end

    // Pointers and occupancy; flush drops contents and any coincident push/pop.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (in_push[i]) wptr <= wptr + IN_AW'(1);
        if (in_pop[i])  rptr <= rptr + IN_AW'(1);
        cnt <= cnt + (IN_AW+1)'(in_push[i]) - (IN_AW+1)'(in_pop[i]);
      end
    end

    // Packet state register.
    always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
    end

    // The beat leaving toward the core decides whether a packet is open.
    always_comb begin
      state_nxt = state;
      if (flush)          state_nxt = IDLE;
      else if (in_pop[i]) state_nxt = in_last[i] ? IDLE : IN_PKT;
    end
  end

  logic [DATA_W:0]   out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wptr, out_rptr;
  logic [OUT_AW:0]   out_cnt;
  pkt_state_t        out_state, out_state_nxt;

  assign out_full   = (out_cnt == OUT_FULL_CNT);
  assign out_empty  = (out_cnt == '0);
  assign out_push   = bus.core_o_valid & ~out_full & ~flush;
  assign out_pop    = bus.m_axis_tready & ~out_empty & ~flush;
  assign out_data   = out_mem[out_rptr][DATA_W-1:0];
  assign out_last   = out_mem[out_rptr][DATA_W];
  assign out_active = (out_state == IN_PKT);

  // Result beat storage, data only.
  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wptr] <= {bus.core_o_last, bus.core_data_out};
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_wptr <= '0;
      out_rptr <= '0;
      out_cnt  <= '0;
    end else begin
      if (out_push) out_wptr <= out_wptr + OUT_AW'(1);
      if (out_pop)  out_rptr <= out_rptr + OUT_AW'(1);
      out_cnt <= out_cnt + (OUT_AW+1)'(out_push) - (OUT_AW+1)'(out_pop);
    end
  end

  // Output packet state register.
  always_ff @(posedge clk) begin
    if (reset) out_state <= IDLE;
    else       out_state <= out_state_nxt;
  end

  // Output packet tracking on m_axis handshakes.
  always_comb begin
    out_state_nxt = out_state;
    if (flush)        out_state_nxt = IDLE;
    else if (out_pop) out_state_nxt = out_last ? IDLE : IN_PKT;
  end

  // ---- stage p1: done pulses registered one cycle after the closing pop ----
  // Flush already masks the pops, so no pulse follows a flushed cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_done_p1  <= '0;
      out_done_p1 <= 1'b0;
    end else begin
      in_done_p1  <= in_pop & in_last;
      out_done_p1 <= out_pop & out_last;
    end
  end

  // Pack per-channel heads into the flat core bus.
  always_comb begin
    bus.core_data_in = '0;
    for (int i = 0; i < NUM_IN; i++) bus.core_data_in[i*DATA_W +: DATA_W] = in_data[i];
  end

  assign bus.s_axis_tready = ~in_full;
  assign bus.core_i_valid  = ~in_empty;
  assign bus.core_i_last   = in_last;
  assign bus.core_o_ready  = ~out_full;
  assign bus.m_axis_tvalid = ~out_empty;
  assign bus.m_axis_tdata  = out_data;
  assign bus.m_axis_tlast  = out_last;

  assign in_pkt_done  = in_done_p1;
  assign out_pkt_done = out_done_p1;
  assign busy = (|(~in_empty)) | (|in_active) | ~out_empty | out_active;

`ifdef MLDSA_AXIS_BRIDGE_STATS_EN
  logic [31:0] in_accepts;
  logic [31:0] in_beats_q, out_beats_q, out_pkts_q;

  // Number of input beats accepted this cycle across all channels.
  always_comb begin
    in_accepts = '0;
    for (int i = 0; i < NUM_IN; i++) in_accepts = in_accepts + 32'(in_push[i]);
  end

  // Free-running wrap-around counters; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_beats_q  <= '0;
      out_beats_q <= '0;
      out_pkts_q  <= '0;
    end else begin
      in_beats_q <= in_beats_q + in_accepts;
      if (out_pop)     out_beats_q <= out_beats_q + 32'd1;
      if (out_done_p1) out_pkts_q  <= out_pkts_q + 32'd1;
    end
  end

  assign stat_in_beats  = in_beats_q;
  assign stat_out_beats = out_beats_q;
  assign stat_out_pkts  = out_pkts_q;
`else
  assign stat_in_beats  = 32'd0;
  assign stat_out_beats = 32'd0;
  assign stat_out_pkts  = 32'd0;
`endif
endmodule

// File: doc/mldsa_axis_bridge.md
MLDSA_AXIS_BRIDGE -- requirements
Module: mldsa_axis_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 64: stream data width in bits.
REQ-002 SHALL have parameter NUM_IN, default 2: number of input stream channels, legal range 1..4.
REQ-003 SHALL have parameter IN_DEPTH, default 4: per-input FIFO depth in beats; power of 2, >=2.
REQ-004 SHALL have parameter OUT_DEPTH, default 4: output FIFO depth in beats; power of 2, >=2.
REQ-005 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have flush  input  1  synchronous clear of all FIFOs and packet state.
REQ-008 SHALL have s_axis_tdata  input  NUM_IN*DATA_W  input channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have s_axis_tvalid / s_axis_tlast  input  NUM_IN each, and s_axis_tready  output  NUM_IN.
REQ-010 SHALL have core_data_in  output  NUM_IN*DATA_W, core_i_valid / core_i_last  output  NUM_IN each, core_i_ready  input  NUM_IN.
REQ-011 SHALL have core_data_out  input  DATA_W, core_o_valid / core_o_last  input  1 each, core_o_ready  output  1.
REQ-012 SHALL have m_axis_tdata  output  DATA_W, m_axis_tvalid / m_axis_tlast  output  1 each, m_axis_tready  input  1.
REQ-013 SHALL have in_pkt_done  output  NUM_IN (1-cycle pulses), out_pkt_done  output  1 (pulse), busy  output  1.
REQ-014 SHALL have stat_in_beats / stat_out_beats / stat_out_pkts  output  32 each.

Function
REQ-015 Each input channel and the output path SHALL be buffered by an independent FIFO storing {tlast, tdata}.
REQ-016 s_axis_tready[i] SHALL equal !full[i]; a beat is accepted when tvalid & tready; same-cycle pop does not make a full FIFO ready.
REQ-017 FIFO read side SHALL be first-word-fall-through: valid = !empty, data/last = head entry, combinationally.
REQ-018 Latency from accept into an empty FIFO to valid at the far side SHALL be exactly 1 cycle; no same-cycle bypass.
REQ-019 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-020 Read/write pointers SHALL wrap modulo depth; occupancy counter width clog2(depth)+1 distinguishes full from empty.
REQ-021 core_o_ready SHALL equal !out_full; m_axis_* SHALL be driven from the output FIFO head.
REQ-022 Each channel and the output path SHALL run a packet FSM with states IDLE (no beat of a packet yet popped) and IN_PKT (mid-packet).
REQ-023 IDLE->IN_PKT on a popped beat with last=0; IN_PKT->IDLE on a popped beat with last=1; an IDLE popped beat with last=1 stays IDLE (single-beat packet).
REQ-024 in_pkt_done[i] / out_pkt_done SHALL pulse for one cycle, registered, the cycle after the last=1 beat is popped at the core or m_axis side.
REQ-025 busy SHALL be 1 whenever any FIFO is non-empty or any packet FSM is in IN_PKT.
REQ-026 flush SHALL empty all FIFOs, return all FSMs to IDLE and suppress done pulses in the same clock edge; flush overrides simultaneous push/pop, which are discarded. Stat counters are not cleared.
REQ-027 Stat counters SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-028 On reset all FIFOs SHALL be empty, all FSMs IDLE, and all stat counters 0.
REQ-029 During and after reset: s_axis_tready all 1, core_o_ready 1, core_i_valid 0, m_axis_tvalid 0, in_pkt_done 0, out_pkt_done 0, busy 0.
REQ-030 Reset asserted mid-packet SHALL discard all buffered beats; the next accepted beat is treated as the start of a packet.
REQ-031 reset SHALL take priority over flush.

Configuration
REQ-032 Macro MLDSA_AXIS_BRIDGE_STATS_EN defined: stat_in_beats counts accepted input beats across all channels (a cycle with k simultaneous accepts adds k), stat_out_beats counts m_axis handshakes, stat_out_pkts counts out_pkt_done pulses.
REQ-033 Macro MLDSA_AXIS_BRIDGE_STATS_EN undefined: no counter logic is built; the stat ports remain and are driven constant 0.

Verification
REQ-034 Reset, then push 1 beat 0xA5 with last=1 on channel 0 -> core_i_valid[0]=1 one cycle later with data 0xA5; in_pkt_done[0] pulses the cycle after the pop.
REQ-035 Hold core_i_ready[1]=0 and push 5 beats on channel 1 with IN_DEPTH=4 -> s_axis_tready[1]=0 after 4 accepts; the 5th beat is accepted only after one pop.
REQ-036 Drive core_o_valid continuously with m_axis_tready toggling 1/0 for 16 beats, last on beat 16 -> m_axis beats appear in order with no loss or duplication; out_pkt_done pulses once.
REQ-037 Assert flush while 3 beats are buffered and a push and a pop coincide -> next cycle all FIFOs empty, busy=0, no done pulse, the pushed beat never appears.
REQ-038 With STATS_EN defined, 2 channels each accept 10 beats concurrently and 7 beats in 2 packets leave m_axis -> stat_in_beats=20, stat_out_beats=7, stat_out_pkts=2; with the macro undefined -> all stats 0.
REQ-039 Assert reset mid-packet with 2 beats buffered -> next cycle core_i_valid=0, busy=0, s_axis_tready all 1.
